// File: rtl/bf16_reduce_ctrl_if.sv
// Command, element stream and bf16_minmax side-band bundle for bf16_reduce_ctrl.
interface bf16_reduce_ctrl_if #(
  parameter int CNT_W = 9
);
  logic             start;
  logic [3:0]       op_sel;
  logic [CNT_W-1:0] length;
  logic             busy;
  logic             elem_valid;
  logic [15:0]      elem_data;
  logic             elem_ready;
  logic             done;
  logic [15:0]      result_o;
  logic             invalid_o;
  logic             mm_enable;
  logic [15:0]      mm_operand_a;
  logic [15:0]      mm_operand_b;
  logic [3:0]       mm_operation;
  logic [15:0]      mm_result;

  modport slave (
    input  start, op_sel, length, elem_valid, elem_data, mm_result,
    output busy, elem_ready, done, result_o, invalid_o,
           mm_enable, mm_operand_a, mm_operand_b, mm_operation
  );

  modport master (
    output start, op_sel, length, elem_valid, elem_data, mm_result,
    input  busy, elem_ready, done, result_o, invalid_o,
           mm_enable, mm_operand_a, mm_operand_b, mm_operation
  );
endinterface

// File: rtl/bf16_reduce_ctrl.sv
// BF16 min/max reduction sequencer: folds a valid/ready element stream into an
// accumulator, one registered bf16_minmax compare per element after the first.
module bf16_reduce_ctrl #(
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  bf16_reduce_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {S_IDLE, S_FIRST, S_NEXT, S_WAIT, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [3:0]       op_q, op_d;
  logic             nan_q, nan_d;
  logic [15:0]      res_q, res_d;
  logic             inv_q, inv_d;

  logic             hs;
  logic             elem_nan;
  logic [CNT_W-1:0] len_sat;

  assign hs       = bus.elem_valid && bus.elem_ready;
  assign elem_nan = (&bus.elem_data[14:7]) && (|bus.elem_data[6:0]);
  assign len_sat  = (bus.length > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : bus.length;

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    rem_d          = rem_q;
    len_d          = len_q;
    op_d           = op_q;
    nan_d          = nan_q;
    res_d          = res_q;
    inv_d          = inv_q;
    bus.elem_ready = 1'b0;
    bus.mm_enable  = 1'b0;
    bus.done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d  = bus.op_sel;
          len_d = len_sat;
          nan_d = 1'b0;
          if (len_sat == '0) begin
            acc_d   = 16'h7FC0;
            state_d = S_DONE;
          end else begin
            state_d = S_FIRST;
          end
        end
      end
      S_FIRST: begin
        bus.elem_ready = 1'b1;
        if (hs) begin
          acc_d   = bus.elem_data;
          rem_d   = len_q - CNT_W'(1);
          nan_d   = nan_q | elem_nan;
          state_d = (len_q == CNT_W'(1)) ? S_DONE : S_NEXT;
        end
      end
      S_NEXT: begin
        bus.elem_ready = 1'b1;
        if (hs) begin
          bus.mm_enable = 1'b1;
          rem_d         = rem_q - CNT_W'(1);
          nan_d         = nan_q | elem_nan;
          state_d       = S_WAIT;
        end
      end
      S_WAIT: begin
        // the unit's output register holds the compare issued last cycle
        acc_d   = bus.mm_result;
        state_d = (rem_q == '0) ? S_DONE : S_NEXT;
      end
      S_DONE: begin
        bus.done = 1'b1;
        res_d    = acc_q;
        inv_d    = nan_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      op_q    <= '0;
      nan_q   <= 1'b0;
      res_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      op_q    <= op_d;
      nan_q   <= nan_d;
      res_q   <= res_d;
      inv_q   <= inv_d;
    end
  end

  // result is already visible in the done cycle, then held from the register
  assign bus.result_o     = (state_q == S_DONE) ? acc_q : res_q;
  assign bus.invalid_o    = (state_q == S_DONE) ? nan_q : inv_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.mm_operand_a = acc_q;
  assign bus.mm_operand_b = bus.elem_data;
  assign bus.mm_operation = op_q;
endmodule

// File: doc/bf16_reduce_ctrl.md
# bf16_reduce_ctrl

Sequencer that runs a vector min/max reduction over a stream of BF16 elements using the shared `bf16_minmax` unit. It accepts a reduction command, pulls elements over a valid/ready stream and keeps a running accumulator. For each element after the first, it issues one compare to the minmax unit and captures the unit's registered result. It sits between the accelerator's command/operand front-end and the `bf16_minmax` instance, and owns that unit's `enable`, operand and `operation` inputs.

## Interface
- `MAX_LEN`, 256, maximum reduction length in elements.
- `CNT_W`, `$clog2(MAX_LEN+1)`, width of the length and remaining-count fields.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  command strobe; accepted only in IDLE.
- `op_sel`  in  4  4'b0011 = min; any other value = max. Latched at start.
- `length`  in  CNT_W  number of elements to reduce, 0..MAX_LEN. Latched at start.
- `busy`  out  1  high in every state except IDLE.
- `elem_valid`  in  1  stream element valid.
- `elem_data`  in  16  BF16 stream element.
- `elem_ready`  out  1  controller can accept an element this cycle.
- `done`  out  1  one-cycle pulse; `result_o` and `invalid_o` are valid from this cycle onward.
- `result_o`  out  16  reduction result; held until the next `done`.
- `invalid_o`  out  1  at least one input element was NaN (exp=8'hFF, mantissa≠0); held with `result_o`.
- `mm_enable`  out  1  enable to the minmax unit.
- `mm_operand_a`  out  16  always the accumulator.
- `mm_operand_b`  out  16  always `elem_data` (combinational pass-through).
- `mm_operation`  out  4  latched `op_sel`.
- `mm_result`  in  16  minmax unit result, registered one cycle after `mm_enable`.

## Operation
FSM states are IDLE, FIRST, NEXT, WAIT and DONE.

- **IDLE:** `elem_ready`=0 and `busy`=0.
  - On `start`, latch `op_sel` and `length` and clear the internal NaN flag.
  - If `length`=0, go to DONE with the accumulator set to 16'h7FC0. Otherwise go to FIRST.
- **FIRST:** `elem_ready`=1.
  - On handshake (`elem_valid`&&`elem_ready`), the accumulator takes `elem_data` and `remaining` takes `length`−1.
  - Go to DONE if `remaining` would be 0; otherwise go to NEXT.
  - The minmax unit is not used in this state.
- **NEXT:** `elem_ready`=1.
  - On handshake, `mm_enable`=1 for that cycle only, and `remaining` decrements. Go to WAIT.
  - Without a handshake, stay in NEXT with `mm_enable`=0.
- **WAIT:** `elem_ready`=0 and `mm_enable`=0.
  - The accumulator takes `mm_result`.
  - Go to DONE if `remaining`=0; otherwise go to NEXT.
- **DONE:** `done`=1 and `busy`=1.
  - `result_o` takes the accumulator and `invalid_o` takes the NaN flag.
  - Go to IDLE.
- **NaN flag:** OR-accumulates the NaN test of `elem_data` on every handshake, in both FIRST and NEXT. NaN elements are still forwarded to the unit. The final value is whatever the unit returns, with no controller override.
- **Busy commands:** `start` while `busy`=1 is ignored, with no effect on latched fields.
- **`length` > MAX_LEN:** saturated to MAX_LEN at latch.
- **Unit status:** the unit's sticky status flags are not consumed. `invalid_o` is computed locally so that it is per-reduction.

## Timing
- **Reset values:** all outputs are 0 — `busy`, `done`, `elem_ready`, `mm_enable`, `result_o`=16'h0000, `invalid_o`, `mm_operation`=4'h0. The FSM goes to IDLE and the accumulator and counters clear.
- **Reset mid-operation:** the command is abandoned and no `done` is produced. Any in-flight `mm_result` is discarded. `result_o`/`invalid_o` read 0.
- **Unit latency:** one clock. The handshake cycle in NEXT is followed by a WAIT capture cycle.
- **Throughput:** 2 cycles per element after the first, with `elem_valid` held high.
- **`done` latency:** for a start accepted in cycle T with `elem_valid` continuously high, `done` is in T+2·`length` when `length`≥1, and in T+1 when `length`=0. Each idle cycle on the stream in FIRST or NEXT adds exactly one cycle.
- **Back-to-back commands:** `start` is accepted in the cycle after `done`, once the FSM is in IDLE.
- **Stream stability:** `elem_data` is sampled only on handshake. The controller never asserts `elem_ready` in IDLE, WAIT or DONE.

## Test plan
- **Max reduction:** `op_sel`=4'b0010, `length`=4, elements 0x3F80, 0x4040, 0xC000, 0x4000, valid always high.
  - `done` at T+8, `result_o`=0x4040, `invalid_o`=0.
  - Exactly 3 `mm_enable` pulses.
- **Min reduction:** `op_sel`=4'b0011, `length`=3, elements 0x3F80, 0xC000, 0x4040 → `result_o`=0xC000 at T+6.
- **Edge lengths:**
  - `length`=0 → `done` at T+1, `result_o`=0x7FC0, `invalid_o`=0, no `elem_ready`.
  - `length`=1 with 0x4120 → `done` at T+2, `result_o`=0x4120, no `mm_enable`.
- **NaN input:** `length`=3 with 0x3F80, 0x7FC1, 0x4000 → `invalid_o`=1 at `done`.
  - A following clean reduction reports `invalid_o`=0.
- **Backpressure and busy start:** `elem_valid` low for 2 cycles in NEXT → `done` delayed by exactly 2 cycles and the result is unchanged.
  - `start` pulsed mid-reduction is ignored.
- **Reset mid-operation:** reset asserted in WAIT → next cycle all outputs are 0 and the FSM is IDLE.
  - A new `start` then completes normally.
